// File: rtl/mix_freq_2_if.sv
// mix_freq_2_if: sample, LO, control and result signals of one mix_freq_2 instance.
//   master : the block that drives samples and control (a sequencer, or the testbench)
//   slave  : the mixer instance
// Samples : ad_pcm_in(_valid), da_lb_pcm_in(_valid), ipcm_in, qpcm_in, iqpcm_valid
// Control : ad_valid, choose_lb, acc_shift, cycle_num, err_clr
// Results : ipcm_acc_out, qpcm_acc_out, err
interface mix_freq_2_if;
    logic               ad_pcm_in_valid;
    logic signed [15:0] ad_pcm_in;
    logic               da_lb_pcm_in_valid;
    logic signed [15:0] da_lb_pcm_in;
    logic signed [15:0] ipcm_in;
    logic signed [15:0] qpcm_in;
    logic               iqpcm_valid;
    logic               ad_valid;
    logic               choose_lb;
    logic [3:0]         acc_shift;
    logic [23:0]        cycle_num;
    logic               err_clr;
    logic signed [31:0] ipcm_acc_out;
    logic signed [31:0] qpcm_acc_out;
    logic [1:0]         err;

    modport master (
        output ad_pcm_in_valid, ad_pcm_in, da_lb_pcm_in_valid, da_lb_pcm_in,
        output ipcm_in, qpcm_in, iqpcm_valid, ad_valid, choose_lb, acc_shift,
        output cycle_num, err_clr,
        input  ipcm_acc_out, qpcm_acc_out, err
    );

    modport slave (
        input  ad_pcm_in_valid, ad_pcm_in, da_lb_pcm_in_valid, da_lb_pcm_in,
        input  ipcm_in, qpcm_in, iqpcm_valid, ad_valid, choose_lb, acc_shift,
        input  cycle_num, err_clr,
        output ipcm_acc_out, qpcm_acc_out, err
    );
endinterface

// File: rtl/mix_freq_2.sv
// mix_freq_2: single-channel, single-frequency IQ mixer/accumulator.
// Multiplies the selected PCM stream by the I and Q LO samples, sums the products
// over cycle_num samples, then publishes the sums, shifted right by acc_shift and
// saturated to 32 bits.
// Ports:
//   clk1 : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mix_freq_2_if.slave (samples, LO, control, results, sticky err)
module mix_freq_2 (
    input logic         clk1,
    input logic         rst,
    mix_freq_2_if.slave bus
);

    localparam logic signed [55:0] SatMax = 56'sd2147483647;
    localparam logic signed [55:0] SatMin = ~SatMax;  // -2^31

    // Stream select and accept / mismatch decode
    logic signed [15:0] s;
    logic               sv;
    logic               acc_en;
    logic               mismatch;

    always_comb begin
        s        = bus.choose_lb ? bus.da_lb_pcm_in : bus.ad_pcm_in;
        sv       = bus.choose_lb ? bus.da_lb_pcm_in_valid : bus.ad_pcm_in_valid;
        acc_en   = bus.ad_valid & sv & bus.iqpcm_valid;
        mismatch = bus.ad_valid & (sv ^ bus.iqpcm_valid);
    end

    // Stage 1: products and window position
    logic [23:0]        cnt_q;
    logic               p_vld_q;
    logic               p_last_q;
    logic signed [31:0] pi_q;
    logic signed [31:0] pq_q;

    logic [23:0]        last_idx;
    logic               cnt_hit;
    logic signed [31:0] s_ext;
    logic signed [31:0] i_ext;
    logic signed [31:0] q_ext;
    logic signed [31:0] pi_d;
    logic signed [31:0] pq_d;

    always_comb begin
        // cycle_num of 0 is treated as a one-sample window
        last_idx = (bus.cycle_num == 24'd0) ? 24'd0 : bus.cycle_num - 24'd1;
        cnt_hit  = (cnt_q >= last_idx);
        s_ext    = 32'(s);
        i_ext    = 32'(bus.ipcm_in);
        q_ext    = 32'(bus.qpcm_in);
        // 16x16 signed products always fit in 32 bits
        pi_d     = s_ext * i_ext;
        pq_d     = s_ext * q_ext;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt_q    <= '0;
            p_vld_q  <= 1'b0;
            p_last_q <= 1'b0;
            pi_q     <= '0;
            pq_q     <= '0;
        end else if (!bus.ad_valid) begin
            cnt_q   <= '0;
            p_vld_q <= 1'b0;
        end else begin
            p_vld_q <= acc_en;
            if (acc_en) begin
                pi_q     <= pi_d;
                pq_q     <= pq_d;
                p_last_q <= cnt_hit;
                cnt_q    <= cnt_hit ? 24'd0 : cnt_q + 24'd1;
            end
        end
    end

    // Stage 2: accumulate, dump on the last product of a window
    logic signed [55:0] acc_i_q;
    logic signed [55:0] acc_q_q;
    logic signed [31:0] out_i_q;
    logic signed [31:0] out_q_q;
    logic [1:0]         err_q;

    logic signed [55:0] sum_i;
    logic signed [55:0] sum_q;
    logic signed [55:0] sh_i;
    logic signed [55:0] sh_q;
    logic signed [31:0] sat_i_val;
    logic signed [31:0] sat_q_val;
    logic               sat_i;
    logic               sat_q;
    logic               dump;
    logic [1:0]         err_d;

    always_comb begin
        sum_i = acc_i_q + 56'(pi_q);
        sum_q = acc_q_q + 56'(pq_q);
        sh_i  = sum_i >>> bus.acc_shift;
        sh_q  = sum_q >>> bus.acc_shift;

        sat_i     = 1'b0;
        sat_i_val = sh_i[31:0];
        if (sh_i > SatMax) begin
            sat_i     = 1'b1;
            sat_i_val = 32'sh7FFF_FFFF;
        end else if (sh_i < SatMin) begin
            sat_i     = 1'b1;
            sat_i_val = 32'sh8000_0000;
        end

        sat_q     = 1'b0;
        sat_q_val = sh_q[31:0];
        if (sh_q > SatMax) begin
            sat_q     = 1'b1;
            sat_q_val = 32'sh7FFF_FFFF;
        end else if (sh_q < SatMin) begin
            sat_q     = 1'b1;
            sat_q_val = 32'sh8000_0000;
        end

        // A product in flight is dropped if ad_valid falls under it
        dump = bus.ad_valid & p_vld_q & p_last_q;

        err_d = err_q;
        if (mismatch) begin
            err_d[0] = 1'b1;
        end
        if (dump && (sat_i || sat_q)) begin
            err_d[1] = 1'b1;
        end
        if (bus.err_clr) begin
            err_d = 2'b00;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            out_i_q <= '0;
            out_q_q <= '0;
            err_q   <= '0;
        end else begin
            err_q <= err_d;
            if (!bus.ad_valid) begin
                acc_i_q <= '0;
                acc_q_q <= '0;
            end else if (p_vld_q) begin
                if (p_last_q) begin
                    out_i_q <= sat_i_val;
                    out_q_q <= sat_q_val;
                    acc_i_q <= '0;
                    acc_q_q <= '0;
                end else begin
                    acc_i_q <= sum_i;
                    acc_q_q <= sum_q;
                end
            end
        end
    end

    assign bus.ipcm_acc_out = out_i_q;
    assign bus.qpcm_acc_out = out_q_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_mix_freq_2.sv
module tb_mix_freq_2;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mix_freq_2_if bus ();

    mix_freq_2 dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    // Present one cycle of inputs then advance past the edge that samples them
    task automatic drive(input logic adv, input logic lbv, input logic iqv,
                         input logic signed [15:0] ad, input logic signed [15:0] lb,
                         input logic signed [15:0] i, input logic signed [15:0] q);
        bus.ad_pcm_in_valid    = adv;
        bus.da_lb_pcm_in_valid = lbv;
        bus.iqpcm_valid        = iqv;
        bus.ad_pcm_in          = ad;
        bus.da_lb_pcm_in       = lb;
        bus.ipcm_in            = i;
        bus.qpcm_in            = q;
        step();
    endtask

    task automatic idle_valids();
        bus.ad_pcm_in_valid    = 1'b0;
        bus.da_lb_pcm_in_valid = 1'b0;
        bus.iqpcm_valid        = 1'b0;
    endtask

    task automatic test_reset();
        bus.ad_valid  = 1'b1;
        bus.choose_lb = 1'b0;
        bus.acc_shift = 4'd0;
        bus.cycle_num = 24'd1;
        bus.err_clr   = 1'b0;
        rst = 1'b1;
        drive(1, 1, 1, 16'sd1234, 16'sd55, 16'sd300, -16'sd77);
        drive(1, 0, 0, 16'sd99, 16'sd5, 16'sd2, 16'sd3);
        total++;
        if (bus.ipcm_acc_out !== 32'sd0) begin
            bad++; $display("FAIL reset_i got=%0d want=0", bus.ipcm_acc_out);
        end
        total++;
        if (bus.qpcm_acc_out !== 32'sd0) begin
            bad++; $display("FAIL reset_q got=%0d want=0", bus.qpcm_acc_out);
        end
        total++;
        if (bus.err !== 2'b00) begin
            bad++; $display("FAIL reset_err got=%b want=00", bus.err);
        end
        rst = 1'b0;
        bus.ad_valid = 1'b0;
        drive(1, 1, 1, 16'sd1234, 16'sd55, 16'sd300, -16'sd77);
        drive(1, 1, 1, 16'sd1234, 16'sd55, 16'sd300, -16'sd77);
        step();
        total++;
        if (bus.ipcm_acc_out !== 32'sd0 || bus.qpcm_acc_out !== 32'sd0 || bus.err !== 2'b00)
        begin
            bad++;
            $display("FAIL post_reset_idle got i=%0d q=%0d err=%b want 0 0 00",
                     bus.ipcm_acc_out, bus.qpcm_acc_out, bus.err);
        end
    endtask

    task automatic test_adc_path();
        idle_valids();
        bus.choose_lb = 1'b0;
        bus.cycle_num = 24'd4;
        bus.acc_shift = 4'd0;
        step();
        bus.ad_valid = 1'b1;
        drive(1, 0, 1, 16'sd100, 16'sd9, 16'sd200, -16'sd50);
        drive(1, 0, 1, 16'sd100, 16'sd9, 16'sd200, -16'sd50);
        total++;
        if (bus.ipcm_acc_out !== 32'sd0) begin
            bad++; $display("FAIL adc_midwindow_hold got=%0d want=0", bus.ipcm_acc_out);
        end
        drive(1, 0, 1, 16'sd100, 16'sd9, 16'sd200, -16'sd50);
        drive(1, 0, 1, 16'sd100, 16'sd9, 16'sd200, -16'sd50);
        total++;
        if (bus.ipcm_acc_out !== 32'sd0) begin
            bad++; $display("FAIL adc_latency_early got=%0d want=0", bus.ipcm_acc_out);
        end
        idle_valids();
        step();
        total++;
        if (bus.ipcm_acc_out !== 32'sd80000) begin
            bad++; $display("FAIL adc_i got=%0d want=80000", bus.ipcm_acc_out);
        end
        total++;
        if (bus.qpcm_acc_out !== -32'sd20000) begin
            bad++; $display("FAIL adc_q got=%0d want=-20000", bus.qpcm_acc_out);
        end
        total++;
        if (bus.err !== 2'b00) begin
            bad++; $display("FAIL adc_err got=%b want=00", bus.err);
        end
        bus.ad_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        idle_valids();
        bus.choose_lb = 1'b1;
        bus.cycle_num = 24'd2;
        bus.acc_shift = 4'd4;
        step();
        bus.ad_valid = 1'b1;
        drive(1, 1, 1, 16'sd7, 16'sd1000, 16'sd1000, 16'sd1000);
        drive(1, 1, 1, 16'sd7, 16'sd1000, 16'sd1000, 16'sd1000);
        drive(1, 1, 1, 16'sd7, 16'sd1000, 16'sd1000, 16'sd1000);
        total++;
        if (bus.ipcm_acc_out !== 32'sd125000 || bus.qpcm_acc_out !== 32'sd125000) begin
            bad++;
            $display("FAIL lb_win1 got i=%0d q=%0d want 125000 125000",
                     bus.ipcm_acc_out, bus.qpcm_acc_out);
        end
        drive(1, 1, 1, 16'sd7, 16'sd1000, 16'sd1000, 16'sd1000);
        drive(1, 1, 1, 16'sd7, 16'sd1000, 16'sd1000, 16'sd1000);
        total++;
        if (bus.ipcm_acc_out !== 32'sd125000 || bus.qpcm_acc_out !== 32'sd125000) begin
            bad++;
            $display("FAIL lb_win2 got i=%0d q=%0d want 125000 125000",
                     bus.ipcm_acc_out, bus.qpcm_acc_out);
        end
        idle_valids();
        bus.ad_valid = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        idle_valids();
        bus.choose_lb = 1'b0;
        bus.cycle_num = 24'd4;
        bus.acc_shift = 4'd0;
        step();
        bus.ad_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, -16'sd32768, 16'sd0, -16'sd32768, 16'sd32767);
        end
        idle_valids();
        step();
        total++;
        if (bus.ipcm_acc_out !== 32'sh7FFF_FFFF) begin
            bad++; $display("FAIL sat_i got=%h want=7fffffff", bus.ipcm_acc_out);
        end
        total++;
        if (bus.qpcm_acc_out !== 32'sh8000_0000) begin
            bad++; $display("FAIL sat_q got=%h want=80000000", bus.qpcm_acc_out);
        end
        total++;
        if (bus.err !== 2'b10) begin
            bad++; $display("FAIL sat_err got=%b want=10", bus.err);
        end
        bus.ad_valid = 1'b0;
        bus.err_clr  = 1'b1;
        step();
        bus.err_clr = 1'b0;
        total++;
        if (bus.err !== 2'b00) begin
            bad++; $display("FAIL sat_err_clr got=%b want=00", bus.err);
        end
        bus.acc_shift = 4'd2;
        step();
        bus.ad_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, -16'sd32768, 16'sd0, -16'sd32768, 16'sd32767);
        end
        idle_valids();
        step();
        total++;
        if (bus.ipcm_acc_out !== 32'sh4000_0000) begin
            bad++; $display("FAIL shift2_i got=%h want=40000000", bus.ipcm_acc_out);
        end
        total++;
        if (bus.qpcm_acc_out !== 32'shC000_8000) begin
            bad++; $display("FAIL shift2_q got=%h want=c0008000", bus.qpcm_acc_out);
        end
        total++;
        if (bus.err !== 2'b00) begin
            bad++; $display("FAIL shift2_err got=%b want=00", bus.err);
        end
        bus.ad_valid = 1'b0;
        step();
    endtask

    task automatic test_mismatch();
        idle_valids();
        bus.cycle_num = 24'd3;
        bus.acc_shift = 4'd0;
        step();
        bus.ad_valid = 1'b1;
        drive(1, 0, 1, 16'sd5, 16'sd0, 16'sd3, -16'sd2);
        // sample valid without LO valid: flagged and discarded
        drive(1, 0, 0, 16'sd1000, 16'sd0, 16'sd1000, 16'sd1000);
        total++;
        if (bus.err !== 2'b01) begin
            bad++; $display("FAIL mismatch_err got=%b want=01", bus.err);
        end
        drive(1, 0, 1, 16'sd5, 16'sd0, 16'sd3, -16'sd2);
        drive(1, 0, 1, 16'sd5, 16'sd0, 16'sd3, -16'sd2);
        idle_valids();
        step();
        total++;
        if (bus.ipcm_acc_out !== 32'sd45 || bus.qpcm_acc_out !== -32'sd30) begin
            bad++;
            $display("FAIL mismatch_sum got i=%0d q=%0d want 45 -30",
                     bus.ipcm_acc_out, bus.qpcm_acc_out);
        end
        // clear wins over a same-cycle mismatch
        bus.err_clr = 1'b1;
        drive(0, 0, 1, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        bus.err_clr = 1'b0;
        total++;
        if (bus.err !== 2'b00) begin
            bad++; $display("FAIL clr_priority got=%b want=00", bus.err);
        end
        bus.ad_valid = 1'b0;
        step();
    endtask

    task automatic test_abort();
        idle_valids();
        bus.cycle_num = 24'd4;
        bus.acc_shift = 4'd0;
        step();
        bus.ad_valid = 1'b1;
        drive(1, 0, 1, 16'sd10, 16'sd0, 16'sd10, 16'sd10);
        drive(1, 0, 1, 16'sd10, 16'sd0, 16'sd10, 16'sd10);
        idle_valids();
        bus.ad_valid = 1'b0;
        step();
        total++;
        if (bus.ipcm_acc_out !== 32'sd45 || bus.qpcm_acc_out !== -32'sd30) begin
            bad++;
            $display("FAIL abort_hold got i=%0d q=%0d want 45 -30",
                     bus.ipcm_acc_out, bus.qpcm_acc_out);
        end
        bus.ad_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 16'sd10, 16'sd0, 16'sd10, 16'sd10);
        end
        idle_valids();
        step();
        total++;
        if (bus.ipcm_acc_out !== 32'sd400 || bus.qpcm_acc_out !== 32'sd400) begin
            bad++;
            $display("FAIL abort_sum got i=%0d q=%0d want 400 400",
                     bus.ipcm_acc_out, bus.qpcm_acc_out);
        end
        bus.ad_valid = 1'b0;
        step();
    endtask

    initial begin
        bus.ad_pcm_in_valid    = 1'b0;
        bus.da_lb_pcm_in_valid = 1'b0;
        bus.iqpcm_valid        = 1'b0;
        bus.ad_pcm_in          = '0;
        bus.da_lb_pcm_in       = '0;
        bus.ipcm_in            = '0;
        bus.qpcm_in            = '0;
        bus.ad_valid           = 1'b0;
        bus.choose_lb          = 1'b0;
        bus.acc_shift          = '0;
        bus.cycle_num          = '0;
        bus.err_clr            = 1'b0;
        test_reset();
        test_adc_path();
        test_back_to_back();
        test_saturation();
        test_mismatch();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_freq_2.md
# mix_freq_2

Single-channel, single-frequency IQ mixer/accumulator. Each instance multiplies one 16-bit PCM stream by an I and a Q local-oscillator sample. It accumulates both products over a programmable number of samples, then publishes scaled, saturated 32-bit I/Q sums. It sits inside the multi-channel, multi-frequency mixer array: one instance per (frequency, channel) pair, with the LO samples shared across channels.

## Interface
Parameters: none.

Ports:
- `clk1`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ad_pcm_in_valid`  in  1  ADC sample valid.
- `ad_pcm_in`  in  16  ADC sample, signed.
- `da_lb_pcm_in_valid`  in  1  DAC-loopback sample valid.
- `da_lb_pcm_in`  in  16  DAC-loopback sample, signed.
- `ipcm_in`  in  16  LO in-phase sample, signed.
- `qpcm_in`  in  16  LO quadrature sample, signed.
- `iqpcm_valid`  in  1  LO sample valid.
- `ad_valid`  in  1  measurement enable.
- `ipcm_acc_out`  out  32  last completed I sum, signed.
- `qpcm_acc_out`  out  32  last completed Q sum, signed.
- `choose_lb`  in  1  1 = use loopback stream, 0 = use ADC stream.
- `acc_shift`  in  4  right-shift applied to sums (0..15).
- `cycle_num`  in  24  samples per accumulation window.
- `err_clr`  in  1  clears err.
- `err`  out  2  sticky errors: [0] sample/LO mismatch, [1] output saturation.

## Operation
- Stream selection: `s` = `choose_lb` ? `da_lb_pcm_in` : `ad_pcm_in`. `sv` = the corresponding valid.
- Accept condition: `acc_en` = `ad_valid & sv & iqpcm_valid`.
- Stage 1, on `acc_en`:
  - `pi` <= `s*ipcm_in` and `pq` <= `s*qpcm_in`, full 32-bit signed products.
  - `p_vld` <= `acc_en`.
  - `p_last` <= (`cnt` >= `max(cycle_num,1)-1`).
  - `cnt` increments on each accepted sample and returns to 0 when `p_last` is set.
- Stage 2, on `p_vld`:
  - Two 56-bit signed accumulators add the sign-extended `pi`/`pq`.
  - If `p_last` is set:
    - `sum` = `acc + p`.
    - Outputs <= `sat32(sum >>> acc_shift)`, arithmetic shift, saturating to [-2^31, 2^31-1].
    - Accumulators <= 0.
  - Outputs otherwise hold.
- `cycle_num` = 0 behaves as 1.
- `cycle_num` and `acc_shift` are used live. Changing them mid-window affects the current window; software changes them only with `ad_valid` low.
- `ad_valid` low clears `cnt`, the accumulators and `p_vld` every cycle. Outputs hold.
- Error bits:
  - `err[0]` is set when `ad_valid` is high and exactly one of `sv`, `iqpcm_valid` is high. That sample is discarded.
  - `err[1]` is set when either I or Q output saturates at a dump.
  - Both bits are sticky.
  - `err_clr` clears both bits and has priority over a same-cycle set.

## Timing
- Reset values: `ipcm_acc_out`, `qpcm_acc_out` = 0; `err` = 0; `cnt`, accumulators, `p_vld`, `p_last` = 0.
- Reset has priority over everything.
- Throughput: one sample per clock.
- Latency: a window's last sample is sampled at edge E0. Outputs and `err[1]` update at edge E1, the next edge, so they are visible 2 cycles after that sample is presented.
- Outputs change only at a dump and remain stable for the whole next window.
- `err[0]` updates at the edge that samples the mismatch.
- Mid-window reset or `ad_valid` drop: the partial window is lost. The next window starts at count 0.

## Test plan
1. Reset: assert `rst` for 2 cycles with arbitrary inputs → outputs 0, `err` 00; after release with `ad_valid`=0 nothing changes.
2. ADC path: `choose_lb`=0, `ad_pcm_in`=100, I=200, Q=-50, `cycle_num`=4, `acc_shift`=0, all valids high 4 cycles → `ipcm_acc_out`=80000, `qpcm_acc_out`=-20000, two cycles after the 4th sample; `err`=00.
3. Loopback/shift: `choose_lb`=1, `da_lb_pcm_in`=1000, `ad_pcm_in`=7, I=Q=1000, `cycle_num`=2, `acc_shift`=4 → both outputs 125000. Back-to-back windows give the same value every 2 samples.
4. Saturation: s=-32768, I=-32768, Q=32767, `cycle_num`=4:
   - `acc_shift`=0 → I=0x7FFFFFFF, Q=0x80000000, `err`=10.
   - `err_clr` pulse → `err`=00.
   - `acc_shift`=2 → I=0x40000000, no error.
5. Mismatch: `ad_pcm_in_valid`=1 with `iqpcm_valid`=0 for one cycle inside a `cycle_num`=3 window → `err[0]`=1 next edge; the window still completes after 3 matched samples with the exact sum. `err_clr` and a new mismatch in the same cycle → `err[0]`=0.
6. Abort: `cycle_num`=4, two samples accepted, `ad_valid` low 1 cycle, then 4 samples of 10×10 → output 400 (not 600); outputs hold their previous value during the abort.
